inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
Parametrised instruction-fetch front end. Owns the PC, issues single-outstanding fetch requests to the icache, and buffers returned instructions with their PCs in a circular queue of 2^DEPTH_LOG2 entries for the decoder. Adds branch/jump redirect with queue flush and in-flight response discard. Sits between the icache/memory controller and decode/dispatch.

Parameters:
ADDR_WIDTH, 32, PC and fetch address width
INST_WIDTH, 32, instruction word width
DEPTH_LOG2, 4, log2 of queue depth (depth 16)
RESET_PC, 0, PC value loaded on reset

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes the whole block
icache_req_valid  out  1  fetch request outstanding
icache_req_addr  out  ADDR_WIDTH  fetch address
icache_resp_valid  in  1  one-cycle response pulse
icache_resp_inst  in  INST_WIDTH  fetched instruction, valid with icache_resp_valid
jump_valid  in  1  redirect request (mispredict/jump)
jump_pc  in  ADDR_WIDTH  redirect target
inst_valid  out  1  queue head valid (count != 0)
inst_out  out  INST_WIDTH  head instruction
inst_pc  out  ADDR_WIDTH  head PC
inst_ready  in  1  decoder pops head when inst_valid && inst_ready
queue_full  out  1  count == 2^DEPTH_LOG2

Behaviour:
- Reset (rst_in=1 at edge; overrides rdy_in): state IDLE, pc=RESET_PC, head=tail=count=0, icache_req_valid=0, icache_req_addr=RESET_PC, inst_valid=0, inst_out=0, inst_pc=0, queue_full=0. The icache shares rst_in, so no stale response follows reset.
- rdy_in=0: no state, pointer, PC or output changes; pops and responses that cycle are ignored (icache is frozen by the same signal).
- Queue: circular buffer; head/tail DEPTH_LOG2 bits wrap naturally; count DEPTH_LOG2+1 bits. Entry = {inst, pc}. inst_out/inst_pc are driven from the head entry; value is don't-care when inst_valid=0, except 0 after reset.
- pop = inst_valid && inst_ready. Push occurs only on an accepted response. Push and pop in the same cycle: count unchanged, both pointers advance.
- States: IDLE, WAIT, DROP. icache_req_valid is registered; it is 1 in WAIT and DROP, 0 in IDLE. icache_req_addr is held stable while the request is outstanding.
- IDLE: if count < depth, request pc, go WAIT (request visible the cycle after issue decision).
- WAIT, icache_resp_valid=1: push {icache_resp_inst, pc}, pc <= pc + 4 (mod 2^ADDR_WIDTH). If count+1-pop < depth, issue the next request at pc+4 immediately and stay WAIT (back-to-back); else req_valid <= 0, go IDLE.
- WAIT without response: hold.
- Full: no request is issued while count == depth. Because one request is outstanding at most and issue requires a free slot, a response never finds the queue full.
- jump_valid=1 (highest priority after reset): flush queue (head=tail=count=0), pc <= jump_pc, inst_valid=0 next cycle, and any pop that cycle is void.
  - In WAIT without a response: go DROP. The request stays asserted at the old address until its response arrives.
  - In WAIT with a response the same cycle: the response is discarded; req_valid <= 0, go IDLE.
  - In IDLE: stay IDLE.
  - In DROP: pc updates, stay DROP.
- DROP: on icache_resp_valid discard the data, req_valid <= 0, go IDLE. The new pc is requested on the following IDLE cycle.
- jump_pc is not alignment-checked; pc increments by 4 regardless.

Test Plan:
- Reset then steady fetch, RESET_PC=0x0, icache returns the word one cycle after req, inst_ready=1 -> requests at 0x0,0x4,0x8...; decoder receives pcs 0x0,0x4,0x8 in order with matching data; no gaps beyond icache latency.
- Fill: inst_ready=0, DEPTH_LOG2=2 -> exactly 4 entries (pc 0x0..0xC); queue_full=1; no request for 0x10 until one pop; after the pop, req addr=0x10.
- Redirect with request in flight: jump_valid with jump_pc=0x100 while WAIT on addr 0x8 -> queue empties next cycle, response for 0x8 discarded, next request addr=0x100, first popped inst_pc=0x100.
- Redirect coincident with a response and a pop -> response not pushed, pop void, count=0, next request 0x100.
- rdy_in low for 3 cycles mid-WAIT with resp_valid pulsed -> no push, no pc change, outputs stable; resumes identically after rdy_in returns.
- Wrap-around: 40 pushes/pops through a depth-16 queue with random inst_ready -> pointers wrap; order and pc pairing preserved. PC at 0xFFFFFFFC increments to 0x0.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: the icache request/response channel, the redirect input and the decoder-facing queue head.
// The fetch queue takes the master modport. Its environment takes the slave modport.
interface inst_fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  icache_req_valid;
  logic [ADDR_WIDTH-1:0] icache_req_addr;
  logic                  icache_resp_valid;
  logic [INST_WIDTH-1:0] icache_resp_inst;
  logic                  jump_valid;
  logic [ADDR_WIDTH-1:0] jump_pc;
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst_out;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_ready;
  logic                  queue_full;

  modport master (
    output icache_req_valid, icache_req_addr, inst_valid, inst_out, inst_pc, queue_full,
    input  icache_resp_valid, icache_resp_inst, jump_valid, jump_pc, inst_ready
  );

  modport slave (
    input  icache_req_valid, icache_req_addr, inst_valid, inst_out, inst_pc, queue_full,
    output icache_resp_valid, icache_resp_inst, jump_valid, jump_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the PC, keeps one icache request in flight,
// and queues {inst, pc} pairs for decode. A redirect flushes the queue and discards any stale response.
module inst_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  inst_fetch_queue_if.master bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2+1:0] DEPTH_CNT = (DEPTH_LOG2+2)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg, pc_next;
  logic [ADDR_WIDTH-1:0]   req_addr_reg, req_addr_next;
  logic                    req_valid_reg, req_valid_next;
  logic [DEPTH_LOG2-1:0]   head_reg, head_next, tail_reg, tail_next;
  logic [DEPTH_LOG2:0]     count_reg, count_next;
  logic [DEPTH_LOG2+1:0]   count_wide, count_after;
  logic                    push, pop, head_valid;
  logic [ADDR_WIDTH-1:0]   pc_plus4;

  logic [INST_WIDTH+ADDR_WIDTH-1:0] mem [DEPTH];

  assign head_valid  = (count_reg != '0);
  assign pop         = head_valid && bus.inst_ready;
  assign pc_plus4    = pc_reg + ADDR_WIDTH'(4);
  assign count_wide  = {1'b0, count_reg};
  // Occupancy after this cycle's push (if any) and pop.
  assign count_after = count_wide + (DEPTH_LOG2+2)'(1) - (DEPTH_LOG2+2)'(pop);

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_addr_next  = req_addr_reg;
    req_valid_next = req_valid_reg;
    head_next      = head_reg;
    tail_next      = tail_reg;
    count_next     = count_reg;
    push           = 1'b0;

    if (bus.jump_valid) begin
      // The redirect voids any pop and any response arriving this cycle.
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
      pc_next    = bus.jump_pc;
      unique case (state_reg)
        WAIT: begin
          if (bus.icache_resp_valid) begin
            req_valid_next = 1'b0;
            state_next     = IDLE;
          end else begin
            state_next = DROP;
          end
        end
        DROP: begin
          if (bus.icache_resp_valid) begin
            req_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (count_wide < DEPTH_CNT) begin
            req_valid_next = 1'b1;
            req_addr_next  = pc_reg;
            state_next     = WAIT;
          end
        end
        WAIT: begin
          if (bus.icache_resp_valid) begin
            push    = 1'b1;
            pc_next = pc_plus4;
            if (count_after < DEPTH_CNT) begin
              req_addr_next = pc_plus4;
            end else begin
              req_valid_next = 1'b0;
              state_next     = IDLE;
            end
          end
        end
        default: begin
          if (bus.icache_resp_valid) begin
            req_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
      endcase
      if (pop)  head_next = head_reg + 1'b1;
      if (push) tail_next = tail_reg + 1'b1;
      count_next = count_reg + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      req_addr_reg  <= RESET_PC;
      req_valid_reg <= 1'b0;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
    end else if (rdy_in) begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      req_addr_reg  <= req_addr_next;
      req_valid_reg <= req_valid_next;
      head_reg      <= head_next;
      tail_reg      <= tail_next;
      count_reg     <= count_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) begin
      mem[tail_reg] <= {bus.icache_resp_inst, pc_reg};
    end
  end

  // The head output is forced to zero while empty, so it reads 0 after reset.
  assign {bus.inst_out, bus.inst_pc} = head_valid ? mem[head_reg] : '0;
  assign bus.inst_valid       = head_valid;
  assign bus.queue_full       = (count_wide == DEPTH_CNT);
  assign bus.icache_req_valid = req_valid_reg;
  assign bus.icache_req_addr  = req_addr_reg;
endmodule
